// File: rtl/ls_seq_pkg.sv
// Shared types and constants for the load/store sequencer.
// Defining LS_SEQ_STORE_EN makes the st opcode legal; without it only ld runs.
// Pure declarations: no logic, no latency, no flow control.
package ls_seq_pkg;

   // Sequencer states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_T7,
      ST_T8,
      ST_ERR
   } state_t;

   // Bus source codes
   localparam logic [4:0] BUS_NONE = 5'b00000;
   localparam logic [4:0] BUS_PC   = 5'b10100;
   localparam logic [4:0] BUS_MDR  = 5'b10101;
   localparam logic [4:0] BUS_ZLO  = 5'b10011;
   localparam logic [4:0] BUS_C    = 5'b10111;

   // ALU operations
   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0011;

   // Opcodes (IR[31:27])
   localparam logic [4:0] OP_LD = 5'b00000;
   localparam logic [4:0] OP_ST = 5'b00001;

   // Memory wait limit: the count reaching this value with no mem_ready is a timeout
   localparam logic [3:0] TIMEOUT_MAX = 4'd15;

`ifdef LS_SEQ_STORE_EN
   localparam bit STORE_EN = 1'b1;
`else
   localparam bit STORE_EN = 1'b0;
`endif

   // Full control word produced by the state decoder
   typedef struct packed {
      logic       busy;
      logic       error;
      logic       incPC;
      logic       e_MAR;
      logic       e_MDR;
      logic       e_IR;
      logic       e_Y;
      logic       e_Z;
      logic       ram_read;
      logic       ram_write;
      logic       MDR_read;
      logic [4:0] bus_sel;
      logic [3:0] alu_op;
      logic       Gra;
      logic       Grb;
      logic       e_Rin;
      logic       e_Rout;
      logic       BAout;
      logic       imm_sel;
   } ctl_t;

   // Opcodes the sequencer knows how to execute
   function automatic logic op_legal(input logic [4:0] op);
      return (op == OP_LD) || (STORE_EN && (op == OP_ST));
   endfunction

   // States that hold for a memory handshake (st swaps which of T7/T8 waits)
   function automatic logic is_wait_state(input state_t s, input logic st);
      return (s == ST_T2) || ((s == ST_T7) && !st) || ((s == ST_T8) && st);
   endfunction

endpackage

// File: rtl/ls_seq_outdec.sv
// Combinational state-to-control decoder for the load/store sequencer (LS_SEQ_STORE_EN adds st controls).
// Latency: zero, pure decode of the registered state and latched store flag.
// No flow control of its own; stalls are expressed by the state simply holding.
module ls_seq_outdec
   import ls_seq_pkg::*;
(
   input  state_t state,
   input  logic   is_st,
   output ctl_t   ctl
);

   // One control word per state; everything defaults to inactive
   always_comb begin
      ctl      = '0;
      ctl.busy = (state != ST_IDLE) && (state != ST_ERR);
      case (state)
         ST_T0: ctl.incPC = 1'b1;
         ST_T1: begin
            ctl.bus_sel = BUS_PC;
            ctl.e_MAR   = 1'b1;
         end
         ST_T2: begin
            ctl.ram_read = 1'b1;
            ctl.MDR_read = 1'b1;
         end
         ST_T3: begin
            ctl.bus_sel = BUS_MDR;
            ctl.e_MDR   = 1'b1;
            ctl.e_IR    = 1'b1;
         end
         ST_T4: begin
            ctl.Grb   = 1'b1;
            ctl.BAout = 1'b1;
            ctl.e_Y   = 1'b1;
         end
         ST_T5: begin
            ctl.imm_sel = 1'b1;
            ctl.bus_sel = BUS_C;
            ctl.alu_op  = ALU_ADD;
            ctl.e_Z     = 1'b1;
         end
         ST_T6: begin
            ctl.bus_sel = BUS_ZLO;
            ctl.e_MAR   = 1'b1;
         end
         ST_T7: begin
            if (is_st && STORE_EN) begin
               // store: drive register Ra onto the bus into MDR (MDR_read stays 0)
               ctl.Gra    = 1'b1;
               ctl.e_Rout = 1'b1;
               ctl.e_MDR  = 1'b1;
            end else begin
               ctl.ram_read = 1'b1;
               ctl.MDR_read = 1'b1;
            end
         end
         ST_T8: begin
            if (is_st && STORE_EN) begin
               ctl.ram_write = 1'b1;
            end else begin
               ctl.bus_sel = BUS_MDR;
               ctl.e_MDR   = 1'b1;
               ctl.Gra     = 1'b1;
               ctl.e_Rin   = 1'b1;
            end
         end
         ST_ERR:  ctl.error = 1'b1;
         default: ctl = ctl;
      endcase
   end

endmodule

// File: rtl/load_store_sequencer.sv
// Load/store fetch+execute sequencer: Moore FSM producing datapath and memory controls (st legal only with LS_SEQ_STORE_EN).
// Latency: one state per clock, outputs decoded from registered state; done is a registered pulse after T8.
// Stalls in memory-wait states until mem_ready (timeout after 15 cycles -> ERR); start ignored while busy.
module load_store_sequencer
   import ls_seq_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic       start,
   input  logic       mem_ready,
   input  logic [4:0] ir_op,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       incPC,
   output logic       e_MAR,
   output logic       e_MDR,
   output logic       e_IR,
   output logic       e_Y,
   output logic       e_Z,
   output logic       ram_read,
   output logic       ram_write,
   output logic       MDR_read,
   output logic [4:0] BusDataSelect,
   output logic [3:0] ALU_op,
   output logic       Gra,
   output logic       Grb,
   output logic       e_Rin,
   output logic       e_Rout,
   output logic       BAout,
   output logic       imm_sel
);

   state_t     state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       is_st_q, is_st_d;
   logic       done_q, done_d;
   logic       in_wait;
   logic       timeout;
   ctl_t       ctl;

   // State register plus wait counter, latched store flag and done pulse
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         is_st_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         is_st_q <= is_st_d;
         done_q  <= done_d;
      end
   end

   // Wait counter: zero outside wait states (so it is clear on entry), counts stalled cycles
   always_comb begin
      in_wait = is_wait_state(state_q, is_st_q);
      timeout = in_wait && !mem_ready && (wcnt_q == (TIMEOUT_MAX - 4'd1));
      wcnt_d  = '0;
      if (in_wait && !mem_ready) begin
         wcnt_d = wcnt_q + 4'd1;
      end
   end

   // Next-state logic; start is only looked at in IDLE and ERR
   always_comb begin
      state_d = state_q;
      is_st_d = is_st_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1:   state_d = ST_T2;
         ST_T2: begin
            if (mem_ready)    state_d = ST_T3;
            else if (timeout) state_d = ST_ERR;
         end
         ST_T3: begin
            // opcode is captured here, as the instruction register loads
            if (op_legal(ir_op)) begin
               state_d = ST_T4;
               is_st_d = STORE_EN && (ir_op == OP_ST);
            end else begin
               state_d = ST_ERR;
            end
         end
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = ST_T6;
         ST_T6:   state_d = ST_T7;
         ST_T7: begin
            if (is_st_q)      state_d = ST_T8;
            else if (mem_ready) state_d = ST_T8;
            else if (timeout) state_d = ST_ERR;
         end
         ST_T8: begin
            if (!is_st_q)       state_d = ST_IDLE;
            else if (mem_ready) state_d = ST_IDLE;
            else if (timeout)   state_d = ST_ERR;
         end
         ST_ERR:  if (start) state_d = ST_T0;
         default: state_d = ST_IDLE;
      endcase
      done_d = (state_q == ST_T8) && (state_d == ST_IDLE);
   end

   ls_seq_outdec u_outdec (
      .state (state_q),
      .is_st (is_st_q),
      .ctl   (ctl)
   );

   // Output mapping from the decoded control word
   always_comb begin
      busy          = ctl.busy;
      done          = done_q;
      error         = ctl.error;
      incPC         = ctl.incPC;
      e_MAR         = ctl.e_MAR;
      e_MDR         = ctl.e_MDR;
      e_IR          = ctl.e_IR;
      e_Y           = ctl.e_Y;
      e_Z           = ctl.e_Z;
      ram_read      = ctl.ram_read;
      ram_write     = ctl.ram_write;
      MDR_read      = ctl.MDR_read;
      BusDataSelect = ctl.bus_sel;
      ALU_op        = ctl.alu_op;
      Gra           = ctl.Gra;
      Grb           = ctl.Grb;
      e_Rin         = ctl.e_Rin;
      e_Rout        = ctl.e_Rout;
      BAout         = ctl.BAout;
      imm_sel       = ctl.imm_sel;
   end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Testbench for load_store_sequencer: per-cycle output trace compared against a phase-list model.
// Stimulus: directed scenarios followed by randomized opcodes and memory stall lengths.
// Model honours LS_SEQ_STORE_EN the same way the design does.
module tb_load_store_sequencer;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       error;
      logic       incPC;
      logic       e_MAR;
      logic       e_MDR;
      logic       e_IR;
      logic       e_Y;
      logic       e_Z;
      logic       ram_read;
      logic       ram_write;
      logic       MDR_read;
      logic [4:0] bds;
      logic [3:0] alu;
      logic       Gra;
      logic       Grb;
      logic       e_Rin;
      logic       e_Rout;
      logic       BAout;
      logic       imm_sel;
   } obs_t;

`ifdef LS_SEQ_STORE_EN
   localparam bit ST_OK = 1'b1;
`else
   localparam bit ST_OK = 1'b0;
`endif

   localparam logic [4:0] LD = 5'b00000;
   localparam logic [4:0] ST = 5'b00001;

   logic       clock = 1'b0;
   logic       clear, start, mem_ready;
   logic [4:0] ir_op;
   logic       busy, done, error, incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z;
   logic       ram_read, ram_write, MDR_read;
   logic [4:0] BusDataSelect;
   logic [3:0] ALU_op;
   logic       Gra, Grb, e_Rin, e_Rout, BAout, imm_sel;

   load_store_sequencer dut (
      .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir_op(ir_op),
      .busy(busy), .done(done), .error(error), .incPC(incPC), .e_MAR(e_MAR), .e_MDR(e_MDR),
      .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .ram_read(ram_read), .ram_write(ram_write),
      .MDR_read(MDR_read), .BusDataSelect(BusDataSelect), .ALU_op(ALU_op), .Gra(Gra),
      .Grb(Grb), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel)
   );

   always #5 clock = ~clock;

   obs_t got;
   assign got = {busy, done, error, incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z, ram_read, ram_write,
                 MDR_read, BusDataSelect, ALU_op, Gra, Grb, e_Rin, e_Rout, BAout, imm_sel};

   int n_chk = 0;
   int n_err = 0;

   obs_t  exp_q[$];
   int    mr_q[$];    // mem_ready to drive in that cycle; -1 means don't care
   string nm_q[$];
   bit    in_err = 1'b0;

   task automatic chk(input string tag, input obs_t exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected outputs for one phase of a sequence
   function automatic obs_t word(input string ph, input bit st);
      obs_t w;
      w = '0;
      w.busy = 1'b1;
      case (ph)
         "T0": w.incPC = 1'b1;
         "T1": begin w.bds = 5'b10100; w.e_MAR = 1'b1; end
         "T2": begin w.ram_read = 1'b1; w.MDR_read = 1'b1; end
         "T3": begin w.bds = 5'b10101; w.e_MDR = 1'b1; w.e_IR = 1'b1; end
         "T4": begin w.Grb = 1'b1; w.BAout = 1'b1; w.e_Y = 1'b1; end
         "T5": begin w.imm_sel = 1'b1; w.bds = 5'b10111; w.alu = 4'b0011; w.e_Z = 1'b1; end
         "T6": begin w.bds = 5'b10011; w.e_MAR = 1'b1; end
         "T7": begin
            if (st) begin w.Gra = 1'b1; w.e_Rout = 1'b1; w.e_MDR = 1'b1; end
            else begin w.ram_read = 1'b1; w.MDR_read = 1'b1; end
         end
         "T8": begin
            if (st) w.ram_write = 1'b1;
            else begin w.bds = 5'b10101; w.e_MDR = 1'b1; w.Gra = 1'b1; w.e_Rin = 1'b1; end
         end
         "ERR":  begin w = '0; w.error = 1'b1; end
         "DONE": begin w = '0; w.done = 1'b1; end
         default: w = '0;
      endcase
      return w;
   endfunction

   task automatic push(input string ph, input bit st, input int mr);
      exp_q.push_back(word(ph, st));
      mr_q.push_back(mr);
      nm_q.push_back(ph);
   endtask

   // A memory wait with s stalled cycles: s+1 cycles in the phase, or 15 cycles then ERR when s >= 15
   task automatic add_wait(input string ph, input bit st, input int s, output bit to);
      int n;
      to = (s >= 15);
      n  = to ? 15 : s + 1;
      for (int i = 0; i < n; i++) push(ph, st, (i < s) ? 0 : 1);
      if (to) push("ERR", 1'b0, -1);
   endtask

   // Whole expected trace of one sequence, starting at the T0 cycle
   task automatic build(input logic [4:0] op, input int s1, input int s2);
      bit to, st, legal;
      exp_q.delete(); mr_q.delete(); nm_q.delete();
      st    = ST_OK && (op == ST);
      legal = (op == LD) || st;
      push("T0", 1'b0, -1);
      push("T1", 1'b0, -1);
      add_wait("T2", 1'b0, s1, to);
      if (to) return;
      push("T3", 1'b0, -1);
      if (!legal) begin
         push("ERR", 1'b0, -1);
         return;
      end
      push("T4", 1'b0, -1);
      push("T5", 1'b0, -1);
      push("T6", 1'b0, -1);
      if (st) begin
         push("T7", 1'b1, -1);
         add_wait("T8", 1'b1, s2, to);
      end else begin
         add_wait("T7", 1'b0, s2, to);
         if (!to) push("T8", 1'b0, -1);
      end
      if (!to) push("DONE", 1'b0, -1);
   endtask

   // Runs one sequence; entered and left just after a rising edge
   task automatic run_txn(input string tag, input logic [4:0] op, input int s1, input int s2,
                          input string abort_ph);
      bit past_t3;
      past_t3 = 1'b0;
      build(op, s1, s2);
      start     = 1'b1;
      ir_op     = op;
      mem_ready = 1'($urandom_range(0, 1));
      #4 chk({tag, ":pre"}, in_err ? word("ERR", 1'b0) : word("IDLE", 1'b0));
      @(posedge clock); #1;
      for (int k = 0; k < exp_q.size(); k++) begin
         start     = exp_q[k].busy ? 1'($urandom_range(0, 1)) : 1'b0;
         ir_op     = past_t3 ? 5'($urandom) : op;
         mem_ready = (mr_q[k] < 0) ? 1'($urandom_range(0, 1)) : 1'(mr_q[k]);
         #4 chk($sformatf("%s:%s#%0d", tag, nm_q[k], k), exp_q[k]);
         if (nm_q[k] == "T3") past_t3 = 1'b1;
         if (nm_q[k] == abort_ph) begin
            #1 clear = 1'b0;
            #1 chk({tag, ":clr"}, '0);
            start     = 1'b1;
            mem_ready = 1'b0;
            @(posedge clock); #1;
            chk({tag, ":clr_hold"}, '0);
            clear = 1'b1;
            start = 1'b0;
            #3 chk({tag, ":clr_rel"}, '0);
            in_err = 1'b0;
            @(posedge clock); #1;
            chk({tag, ":clr_idle"}, '0);
            return;
         end
         @(posedge clock); #1;
      end
      in_err = exp_q[exp_q.size() - 1].error;
   endtask

   initial begin
      logic [4:0] op;
      int s[2];
      clear     = 1'b0;
      start     = 1'b1;
      ir_op     = LD;
      mem_ready = 1'b1;
      #12 chk("reset_a", '0);
      #10 chk("reset_b", '0);
      #8;
      clear = 1'b1;
      run_txn("ld_basic", LD, 0, 0, "");
      run_txn("ld_stall3", LD, 3, 1, "");
      run_txn("ld_to_t7", LD, 0, 15, "");
      run_txn("ld_from_err", LD, 2, 0, "");
      run_txn("ld_edge14", LD, 14, 14, "");
      run_txn("t2_to", LD, 15, 0, "");
      run_txn("bad_op", 5'b11111, 0, 0, "");
      run_txn("st", ST, 0, 2, "");
      run_txn("st_to", ST, 1, 15, "");
      run_txn("clr_t5", LD, 0, 0, "T5");
      run_txn("clr_t2", LD, 6, 0, "T2");
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0, 1:    op = LD;
            2:       op = ST;
            default: op = 5'($urandom_range(2, 31));
         endcase
         for (int j = 0; j < 2; j++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: s[j] = $urandom_range(0, 3);
               6, 7:             s[j] = $urandom_range(4, 13);
               8:                s[j] = 14;
               default:          s[j] = $urandom_range(15, 17);
            endcase
         end
         run_txn($sformatf("rnd%0d", t), op, s[0], s[1], "");
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_sequencer.md
LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have ports, clock and reset first:
- clock  in  1  rising-edge system clock.
- clear  in  1  asynchronous active-low reset (0 = reset).
- start  in  1  request to run one fetch+execute sequence.
- mem_ready  in  1  RAM access complete; sampled in memory-wait states.
- ir_op  in  5  IR[31:27] opcode from the datapath.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- error  out  1  sticky; set on illegal opcode or memory timeout.
- incPC, e_MAR, e_MDR, e_IR, e_Y, e_Z  out  1 each  datapath enables.
- ram_read, ram_write, MDR_read  out  1 each  memory controls.
- BusDataSelect  out  5  bus source code.
- ALU_op  out  4  ALU operation.
- Gra, Grb, e_Rin, e_Rout, BAout, imm_sel  out  1 each  register-select controls.

Function
REQ-003 SHALL be a Moore FSM; all outputs decode from the registered state only.
REQ-004 States: IDLE, T0 through T8, ERR.
REQ-005 IDLE: all datapath outputs 0, BusDataSelect 0; on start=1 go to T0.
REQ-006 T0: incPC=1.
REQ-007 T1: BusDataSelect=BUS_PC (5'b10100), e_MAR=1.
REQ-008 T2: ram_read=1, MDR_read=1; hold until mem_ready=1.
REQ-009 T3: BusDataSelect=BUS_MDR (5'b10101), e_MDR=1, e_IR=1.
REQ-010 T4: Grb=1, BAout=1, e_Y=1; ir_op sampled on entry.
- ld = 5'b00000 continues.
- Illegal opcode goes to ERR instead of T4.
REQ-011 T5: imm_sel=1, BusDataSelect=BUS_C (5'b10111), ALU_op=ALU_ADD (4'b0011), e_Z=1.
REQ-012 T6: BusDataSelect=BUS_ZLO (5'b10011), e_MAR=1.
REQ-013 ld T7: ram_read=1, MDR_read=1; hold until mem_ready=1.
REQ-014 ld T8: BusDataSelect=BUS_MDR, e_MDR=1, Gra=1, e_Rin=1.
REQ-015 After T8: done=1 for one cycle, return to IDLE.
REQ-016 A 4-bit wait counter SHALL clear on entry to any wait state and increment each cycle while mem_ready=0.
- Timeout occurs when the count reaches 15 with mem_ready still 0.
- On timeout go to ERR.
REQ-017 ERR: error=1, all datapath outputs 0.
- Leave ERR only on start=1, which clears error and goes to T0.
REQ-018 busy=1 in every state except IDLE and ERR.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 mem_ready SHALL be ignored outside wait states.
REQ-021 A simultaneous start and timeout SHALL resolve as the timeout (go to ERR).

Reset
REQ-022 clear=0 SHALL force IDLE, wait counter 0, error 0, done 0, all outputs 0, regardless of state; this includes the middle of a wait state.
REQ-023 The first transition SHALL occur on the first rising edge after clear rises.

Configuration
REQ-024 With LS_SEQ_STORE_EN defined, st (5'b00001) SHALL be legal.
- st T7: Gra=1, e_Rout=1, e_MDR=1, MDR_read=0.
- st T8: ram_write=1; hold until mem_ready=1, with the same timeout rule as REQ-016.
- Then done, return to IDLE.
REQ-025 Without LS_SEQ_STORE_EN, st SHALL be illegal, and e_Rout and ram_write SHALL be tied 0.

Structure
REQ-026 Package ls_seq_pkg SHALL hold:
- the state enum;
- BUS_PC, BUS_MDR, BUS_ZLO, BUS_C;
- ALU_ADD;
- OP_LD, OP_ST;
- TIMEOUT_MAX = 15.
REQ-027 The sequencer SHALL contain one sub-module, ls_seq_outdec: a combinational state-to-control decoder. Next-state logic and the wait counter stay in the top module.

Verification
REQ-028 Scenario: clear=0 for 30 ns, then start=1, ir_op=0, mem_ready=1.
- Expected: states T0..T8 on consecutive cycles.
- BusDataSelect 10100 at T1 and 10011 at T6.
- done pulses exactly once, 10 cycles after start.
REQ-029 Scenario: mem_ready=0 for 3 cycles in T2.
- Expected: T2 held 4 cycles with ram_read=1 throughout, then T3.
REQ-030 Scenario: mem_ready held 0 in T7.
- Expected: ERR after 15 cycles, error=1, all enables 0.
- A following start=1 clears error and enters T0.
REQ-031 Scenario: ir_op=5'b11111 at T3.
- Expected: ERR, error=1, no e_Y assertion.
REQ-032 Scenario: clear pulsed low during T5.
- Expected: immediate IDLE, all outputs 0, no done.
REQ-033 Scenario: with LS_SEQ_STORE_EN, ir_op=5'b00001.
- Expected: T7 shows Gra=1 and e_Rout=1; T8 shows ram_write=1; then done.
- Without the macro, the same stimulus goes to ERR.
